// File: rtl/systolic_pkg.sv
// Shared defaults, feeder state encoding and lane-slice helpers for the systolic input path.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANE_COUNT = 16;
  localparam int DEF_TILE_DEPTH = 16;
  localparam int DEF_VEC_WIDTH  = DEF_LANE_COUNT * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } feeder_state_t;

  // Bit offset of a lane's element inside a packed lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Tile storage: DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module feeder_buf #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tile_feeder.sv
// Buffers one lane-vector tile from a ready/valid stream and replays it, one masked vector
// per cycle, into the skew buffer bank. TILE_FEEDER_ZERO_FLUSH_EN adds a zero-data flush tail.
module tile_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_COUNT = DEF_LANE_COUNT,
  parameter int TILE_DEPTH = DEF_TILE_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [LANE_COUNT*DATA_WIDTH-1:0]      s_data,
  input  logic                                  s_last,
  input  logic                                  start,
  input  logic [LANE_COUNT-1:0]                 lane_mask,
  output logic [LANE_COUNT-1:0]                 out_valid,
  output logic [LANE_COUNT*DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(TILE_DEPTH+1)-1:0]       tile_len,
  output logic                                  busy,
  output logic                                  done
);

  localparam int VEC_W = LANE_COUNT * DATA_WIDTH;
  localparam int PTR_W = $clog2(TILE_DEPTH);
  localparam int LEN_W = $clog2(TILE_DEPTH + 1);

  feeder_state_t         state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]      tile_len_q, tile_len_d;
  logic [LANE_COUNT-1:0] mask_q, mask_d;
  logic                  tail_q, tail_d;
  logic [LANE_COUNT-1:0] out_valid_q, out_valid_d;
  logic [VEC_W-1:0]      out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic                  finish;
  logic                  accept;
  logic [VEC_W-1:0]      rd_vec, rd_masked;

`ifdef TILE_FEEDER_ZERO_FLUSH_EN
  localparam int FC_W = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
  logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
`endif

  assign s_ready = (state_q == IDLE);
  assign accept  = s_valid & s_ready;

  feeder_buf #(
    .DEPTH (TILE_DEPTH),
    .WIDTH (VEC_W),
    .ADDR_W(PTR_W)
  ) u_buf (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr_q),
    .wdata(s_data),
    .raddr(rd_ptr_q),
    .rdata(rd_vec)
  );

  for (genvar i = 0; i < LANE_COUNT; i++) begin : g_lane
    assign rd_masked[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
      mask_q[i] ? rd_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tile_len_d  = tile_len_q;
    mask_d      = mask_q;
    tail_d      = tail_q;
    out_valid_d = '0;
    out_data_d  = '0;
    done_d      = 1'b0;
    finish      = 1'b0;
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
    flush_cnt_d = flush_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          tile_len_d = tile_len_q + LEN_W'(1);
          if (s_last || tile_len_q == LEN_W'(TILE_DEPTH - 1)) state_d = LOADED;
        end
      end
      LOADED: begin
        if (start) begin
          mask_d  = lane_mask;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // tail_q marks that the final vector is already on the outputs.
        if (!tail_q) begin
          out_valid_d = mask_q;
          out_data_d  = rd_masked;
          if (LEN_W'(rd_ptr_q) + LEN_W'(1) == tile_len_q) tail_d = 1'b1;
          else rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
          state_d     = FLUSH;
          out_valid_d = mask_q;
          flush_cnt_d = FC_W'(1);
`else
          finish = 1'b1;
`endif
        end
      end
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
      FLUSH: begin
        if (flush_cnt_q == FC_W'(LANE_COUNT - 1)) begin
          finish = 1'b1;
        end else begin
          out_valid_d = mask_q;
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tile_len_d = '0;
      tail_d     = 1'b0;
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
      flush_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tile_len_q  <= '0;
      mask_q      <= '0;
      tail_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tile_len_q  <= tile_len_d;
      mask_q      <= mask_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tile_len  = tile_len_q;
  assign done      = done_q;
  assign busy      = (state_q == DRAIN) || (state_q == FLUSH);

endmodule

// File: tb/tb_tile_feeder.sv
// Directed bench for tile_feeder: per-cycle rows of {inputs, expected outputs} applied in order.
module tb_tile_feeder;

  localparam int DW = 8;
  localparam int LC = 16;
  localparam int TD = 16;
  localparam int VW = LC * DW;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, s_last, start, busy, done;
  logic [VW-1:0] s_data, out_data;
  logic [LC-1:0] lane_mask, out_valid;
  logic [4:0]    tile_len;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tile_feeder #(.DATA_WIDTH(DW), .LANE_COUNT(LC), .TILE_DEPTH(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .start    (start),
    .lane_mask(lane_mask),
    .out_valid(out_valid),
    .out_data (out_data),
    .tile_len (tile_len),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic          rst;
    logic          sv;
    logic [VW-1:0] sd;
    logic          sl;
    logic          st;
    logic [LC-1:0] mk;
    logic          e_rdy;
    logic [LC-1:0] e_ov;
    logic [VW-1:0] e_od;
    logic [4:0]    e_tl;
    logic          e_busy;
    logic          e_done;
  } row_t;

  row_t tbl[$];

  // Lane i of vector k holds base + k*16 + i; lanes outside m read as zero.
  function automatic logic [VW-1:0] vd(input int k, input logic [7:0] base, input logic [LC-1:0] m);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < LC; i++)
      if (m[i]) v[i*DW +: DW] = base + 8'(k * 16 + i);
    return v;
  endfunction

  function automatic row_t mk_row(
    input logic r, input logic sv, input logic [VW-1:0] sd, input logic sl, input logic st,
    input logic [LC-1:0] mk, input logic e_rdy, input logic [LC-1:0] e_ov,
    input logic [VW-1:0] e_od, input logic [4:0] e_tl, input logic e_busy, input logic e_done);
    row_t x;
    x.rst = r;  x.sv = sv;  x.sd = sd;  x.sl = sl;  x.st = st;  x.mk = mk;
    x.e_rdy = e_rdy;  x.e_ov = e_ov;  x.e_od = e_od;  x.e_tl = e_tl;
    x.e_busy = e_busy;  x.e_done = e_done;
    return x;
  endfunction

  function automatic void push(input row_t r);
    tbl.push_back(r);
  endfunction

  // n beats ending with s_last; tile_len counts up from zero.
  function automatic void push_beats(input int n, input logic [7:0] base, input logic st);
    for (int k = 0; k < n; k++)
      push(mk_row(1'b0, 1'b1, vd(k, base, '1), k == n - 1, st, '0,
                  k != n - 1, '0, '0, 5'(k + 1), 1'b0, 1'b0));
  endfunction

  // Start edge, n masked data cycles, optional zero flush, done pulse, one idle cycle.
  // lane_mask is driven to ~m after the start edge so only the latched mask may matter.
  function automatic void push_replay(input int n, input logic [7:0] base, input logic [LC-1:0] m,
                                      input logic hold);
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b1, m, 1'b0, '0, '0, 5'(n), 1'b1, 1'b0));
    for (int k = 0; k < n; k++)
      push(mk_row(1'b0, 1'b0, '0, 1'b0, hold, ~m, 1'b0, m, vd(k, base, m), 5'(n), 1'b1, 1'b0));
`ifdef TILE_FEEDER_ZERO_FLUSH_EN
    for (int j = 0; j < LC - 1; j++)
      push(mk_row(1'b0, 1'b0, '0, 1'b0, hold, ~m, 1'b0, m, '0, 5'(n), 1'b1, 1'b0));
`endif
    push(mk_row(1'b0, 1'b0, '0, 1'b0, hold, ~m, 1'b1, '0, '0, 5'd0, 1'b0, 1'b1));
    push(mk_row(1'b0, 1'b0, '0, 1'b0, hold, ~m, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step(input row_t r, input string tag);
    rst       = r.rst;
    s_valid   = r.sv;
    s_data    = r.sd;
    s_last    = r.sl;
    start     = r.st;
    lane_mask = r.mk;
    @(posedge clk);
    #1;
    chk({tag, ".s_ready"},   VW'(s_ready),   VW'(r.e_rdy));
    chk({tag, ".out_valid"}, VW'(out_valid), VW'(r.e_ov));
    chk({tag, ".out_data"},  out_data,       r.e_od);
    chk({tag, ".tile_len"},  VW'(tile_len),  VW'(r.e_tl));
    chk({tag, ".busy"},      VW'(busy),      VW'(r.e_busy));
    chk({tag, ".done"},      VW'(done),      VW'(r.e_done));
  endtask

  task automatic run_seq(input string tag);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", tag, i));
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;  s_valid = 1'b0;  s_data = '0;  s_last = 1'b0;  start = 1'b0;  lane_mask = '0;

    // Reset, a full-mask 4-vector tile, then a half-mask 3-vector tile.
    push(mk_row(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push(mk_row(1'b1, 1'b1, '1, 1'b1, 1'b1, '1, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push_beats(4, 8'h00, 1'b0);
    push_replay(4, 8'h00, 16'hFFFF, 1'b0);
    push_beats(3, 8'h40, 1'b0);
    push_replay(3, 8'h40, 16'h00FF, 1'b0);
    run_seq("tbl");

    // 16 beats without s_last; a 17th beat offered in LOADED must be refused.
    for (int k = 0; k < TD; k++)
      push(mk_row(1'b0, 1'b1, vd(k, 8'h80, '1), 1'b0, 1'b0, '0,
                  k != TD - 1, '0, '0, 5'(k + 1), 1'b0, 1'b0));
    push(mk_row(1'b0, 1'b1, {VW{1'b1}}, 1'b1, 1'b0, '0, 1'b0, '0, '0, 5'd16, 1'b0, 1'b0));
    push_replay(TD, 8'h80, 16'hFFFF, 1'b0);
    run_seq("full");

    // start held high throughout: ignored in empty IDLE, during fill and with s_last.
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b1, '1, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push_beats(2, 8'h20, 1'b1);
    push_replay(2, 8'h20, 16'hF0F0, 1'b1);
    run_seq("hold");

    // Reset during the second DRAIN cycle, then a fresh 2-vector tile.
    push_beats(3, 8'hC0, 1'b0);
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b1, '1, 1'b0, '0, '0, 5'd3, 1'b1, 1'b0));
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '1, vd(0, 8'hC0, '1), 5'd3, 1'b1, 1'b0));
    push(mk_row(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push(mk_row(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, '0, '0, 5'd0, 1'b0, 1'b0));
    push_beats(2, 8'h10, 1'b0);
    push_replay(2, 8'h10, 16'hFFFF, 1'b0);
    run_seq("rst");

    // Short tile; with the zero flush enabled this exercises the 15-cycle tail.
    push_beats(2, 8'h30, 1'b0);
    push_replay(2, 8'h30, 16'hFFFF, 1'b0);
    run_seq("two");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
